// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode encoding and command layout for the ALU issue stage
package alu_pkg;

    localparam int DW  = 8;
    localparam int OPW = 4;
    localparam int RW  = 16;

    typedef enum logic [OPW-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_SHL    = 4'd3,
        OP_SHR    = 4'd4,
        OP_PASS_A = 4'd5,
        OP_PASS_B = 4'd6,
        OP_AND    = 4'd7,
        OP_OR     = 4'd8,
        OP_NAND   = 4'd9,
        OP_XOR    = 4'd10,
        OP_XNOR   = 4'd11,
        OP_EQ     = 4'd12,
        OP_MAX    = 4'd13,
        OP_MAX2   = 4'd14,
        OP_ILL    = 4'd15
    } opcode_e;

    // FIFO entry layout, most significant field first.
    typedef struct packed {
        logic           chain;
        logic [OPW-1:0] opcode;
        logic [DW-1:0]  in1;
        logic [DW-1:0]  in2;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - command, ALU and result signal bundle for the ALU issue stage
// Ports (slave = issue stage side):
//   flush                      synchronous clear
//   cmd_valid/ready, cmd_*     command handshake and payload
//   alu_in1/in2/opcode         registered operands to the ALU, alu_result back
//   res_valid/ready, res_*     result handshake, payload and flags
//   fifo_count                 command FIFO occupancy
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = alu_pkg::DW,
    parameter int OPW   = alu_pkg::OPW,
    parameter int RW    = alu_pkg::RW
);
    localparam int CW = $clog2(DEPTH + 1);

    logic           flush;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_opcode;
    logic [DW-1:0]  cmd_in1;
    logic [DW-1:0]  cmd_in2;
    logic           cmd_chain;
    logic [DW-1:0]  alu_in1;
    logic [DW-1:0]  alu_in2;
    logic [OPW-1:0] alu_opcode;
    logic [RW-1:0]  alu_result;
    logic           res_valid;
    logic           res_ready;
    logic [RW-1:0]  res_data;
    logic [OPW-1:0] res_opcode;
    logic           res_zero;
    logic           res_ovf;
    logic           res_ill;
    logic [CW-1:0]  fifo_count;

    modport slave (
        input  flush, cmd_valid, cmd_opcode, cmd_in1, cmd_in2, cmd_chain,
               alu_result, res_ready,
        output cmd_ready, alu_in1, alu_in2, alu_opcode,
               res_valid, res_data, res_opcode, res_zero, res_ovf, res_ill, fifo_count
    );

    modport master (
        output flush, cmd_valid, cmd_opcode, cmd_in1, cmd_in2, cmd_chain,
               alu_result, res_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_opcode,
               res_valid, res_data, res_opcode, res_zero, res_ovf, res_ill, fifo_count
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count and flush
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_flush              synchronous clear, overrides push/pop
//   i_push, i_wdata      write strobe and entry (caller guarantees not full)
//   i_pop, o_rdata       read strobe and head entry (caller guarantees not empty)
//   o_count, o_full, o_empty  occupancy status
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int W     = alu_pkg::CMD_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_wdata,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO, operand register and result register around an external ALU
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        alu_issue_stage_if.slave: command in, ALU operands out / result in, result out
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = alu_pkg::DW,
    parameter int OPW   = alu_pkg::OPW,
    parameter int RW    = alu_pkg::RW
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   bus
);
    localparam int W  = 1 + OPW + 2 * DW;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]   w_head;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_s1_load;
    logic           w_s2_load;
    logic           w_head_chain;
    logic [OPW-1:0] w_head_opcode;
    logic [DW-1:0]  w_head_in1;
    logic [DW-1:0]  w_head_in2;
    logic [DW-1:0]  w_fwd;
    logic [DW-1:0]  w_in1_sel;

    logic           r_s1_valid;
    logic [DW-1:0]  r_alu_in1;
    logic [DW-1:0]  r_alu_in2;
    logic [OPW-1:0] r_alu_opcode;
    logic           r_res_valid;
    logic [RW-1:0]  r_res_data;
    logic [OPW-1:0] r_res_opcode;
    logic           r_res_zero;
    logic           r_res_ovf;
    logic           r_res_ill;
    logic [DW-1:0]  r_last_lo;     // only the low byte of the previous result is ever forwarded

    // cmd_ready deliberately ignores a same-cycle pop.
    assign w_push = bus.cmd_valid && !w_full;

    alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_wdata ({bus.cmd_chain, bus.cmd_opcode, bus.cmd_in1, bus.cmd_in2}),
        .i_pop   (w_s1_load),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_chain  = w_head[W-1];
    assign w_head_opcode = w_head[W-2 -: OPW];
    assign w_head_in1    = w_head[2*DW-1 -: DW];
    assign w_head_in2    = w_head[DW-1:0];

    assign w_s2_load = r_s1_valid && (!r_res_valid || bus.res_ready);
    assign w_s1_load = !w_empty && (!r_s1_valid || w_s2_load);

    // When the producer of the chained operand leaves S1 at this same edge its
    // result is not yet in last_result, so take it straight off the ALU.
    assign w_fwd     = w_s2_load ? bus.alu_result[DW-1:0] : r_last_lo;
    assign w_in1_sel = w_head_chain ? w_fwd : w_head_in1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_opcode <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_opcode <= '0;
            r_res_zero   <= 1'b0;
            r_res_ovf    <= 1'b0;
            r_res_ill    <= 1'b0;
            r_last_lo    <= '0;
        end else if (bus.flush) begin
            r_s1_valid  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_res_ill   <= 1'b0;
            r_last_lo   <= '0;
        end else begin
            if (w_s2_load) begin
                r_res_valid  <= 1'b1;
                r_res_data   <= bus.alu_result;
                r_res_opcode <= r_alu_opcode;
                r_res_zero   <= (bus.alu_result == '0);
                r_res_ovf    <= |bus.alu_result[RW-1:DW];
                r_res_ill    <= (r_alu_opcode == OPW'(OP_ILL));
                r_last_lo    <= bus.alu_result[DW-1:0];
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end

            if (w_s1_load) begin
                r_s1_valid   <= 1'b1;
                r_alu_in1    <= w_in1_sel;
                r_alu_in2    <= w_head_in2;
                r_alu_opcode <= w_head_opcode;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.fifo_count = w_count;
    assign bus.alu_in1    = r_alu_in1;
    assign bus.alu_in2    = r_alu_in2;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_opcode = r_res_opcode;
    assign bus.res_zero   = r_res_zero;
    assign bus.res_ovf    = r_res_ovf;
    assign bus.res_ill    = r_res_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   acc;

    alu_issue_stage_if #(.DEPTH(DEPTH), .DW(DW), .OPW(OPW), .RW(RW)) bus ();

    alu_issue_stage #(.DEPTH(DEPTH), .DW(DW), .OPW(OPW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the parent's combinational ALU.
    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  alu_f = 16'(a) + 16'(b);
            OP_SUB:  alu_f = 16'(a) - 16'(b);
            OP_MUL:  alu_f = 16'(a) * 16'(b);
            OP_XOR:  alu_f = 16'(a ^ b);
            default: alu_f = 16'h0000;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_opcode, bus.alu_in1, bus.alu_in2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_in1    = a;
        bus.cmd_in2    = b;
        bus.cmd_chain  = ch;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_in1    = '0;
        bus.cmd_in2    = '0;
        bus.cmd_chain  = 1'b0;
        bus.res_ready  = 1'b0;
        tick();
        tick();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_alu_in1", bus.alu_in1, 0);
        chk("rst_res_data", bus.res_data, 0);
        rst = 1'b0;

        // Basic add: 200 + 100 = 0x012C, overflow into high byte
        bus.res_ready = 1'b1;
        drive(OP_ADD, 8'd200, 8'd100, 1'b0);
        chk("add_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("add_lat1_valid", bus.res_valid, 0);
        chk("add_count1", bus.fifo_count, 1);
        tick();
        chk("add_lat2_valid", bus.res_valid, 0);
        chk("add_alu_in1", bus.alu_in1, 200);
        tick();
        chk("add_res_valid", bus.res_valid, 1);
        chk("add_res_data", bus.res_data, 16'h012C);
        chk("add_ovf", bus.res_ovf, 1);
        chk("add_zero", bus.res_zero, 0);
        chk("add_ill", bus.res_ill, 0);
        chk("add_opcode", bus.res_opcode, 0);
        tick();
        chk("add_drained", bus.res_valid, 0);

        // Chained forwarding back-to-back: 3*5=15, then 15+1=16
        drive(OP_MUL, 8'd3, 8'd5, 1'b0);
        tick();
        drive(OP_ADD, 8'hEE, 8'd1, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("chain_mul_valid", bus.res_valid, 1);
        chk("chain_mul_data", bus.res_data, 16'h000F);
        tick();
        chk("chain_add_valid", bus.res_valid, 1);
        chk("chain_add_data", bus.res_data, 16'h0010);
        tick();
        chk("chain_drained", bus.res_valid, 0);

        // Backpressure: 6 of 8 accepted, then drain in order
        bus.res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(OP_ADD, 8'(i + 1), 8'd0, 1'b0);
            if (bus.cmd_ready) acc++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted", acc, 6);
        chk("bp_cmd_ready", bus.cmd_ready, 0);
        chk("bp_fifo_count", bus.fifo_count, 4);
        chk("bp_res_data", bus.res_data, 1);
        tick();
        chk("bp_res_stable", bus.res_data, 1);
        chk("bp_alu_in1_stable", bus.alu_in1, 2);
        bus.res_ready = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk("bp_drain_valid", bus.res_valid, 1);
            chk("bp_drain_data", bus.res_data, i);
        end
        tick();
        chk("bp_end_valid", bus.res_valid, 0);
        chk("bp_end_count", bus.fifo_count, 0);

        // Zero flag on XOR of equal operands
        drive(OP_XOR, 8'h5A, 8'h5A, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("xor_valid", bus.res_valid, 1);
        chk("xor_data", bus.res_data, 0);
        chk("xor_zero", bus.res_zero, 1);
        chk("xor_ill", bus.res_ill, 0);
        tick();

        // Illegal opcode
        drive(OP_ILL, 8'd3, 8'd4, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("ill_valid", bus.res_valid, 1);
        chk("ill_data", bus.res_data, 0);
        chk("ill_flag", bus.res_ill, 1);
        chk("ill_zero", bus.res_zero, 1);
        chk("ill_opcode", bus.res_opcode, 15);
        tick();

        // Flush mid-stream, then chain must start from 0
        bus.res_ready = 1'b0;
        drive(OP_ADD, 8'd1, 8'd1, 1'b0);
        tick();
        drive(OP_ADD, 8'd2, 8'd2, 1'b0);
        tick();
        drive(OP_ADD, 8'd3, 8'd3, 1'b0);
        tick();
        chk("fl_pre_data", bus.res_data, 2);
        chk("fl_pre_count", bus.fifo_count, 1);
        drive(OP_ADD, 8'd9, 8'd9, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("fl_res_valid", bus.res_valid, 0);
        chk("fl_fifo_count", bus.fifo_count, 0);
        chk("fl_res_data", bus.res_data, 0);
        tick();
        chk("fl_dropped_cmd", bus.fifo_count, 0);
        bus.res_ready = 1'b1;
        drive(OP_ADD, 8'h99, 8'd7, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("fl_chain_valid", bus.res_valid, 1);
        chk("fl_chain_data", bus.res_data, 7);
        tick();

        // Asynchronous reset with a full pipeline
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(OP_ADD, 8'(i + 1), 8'd0, 1'b0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("ar_pre_count", bus.fifo_count, 4);
        chk("ar_pre_valid", bus.res_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_res_valid", bus.res_valid, 0);
        chk("ar_fifo_count", bus.fifo_count, 0);
        chk("ar_cmd_ready", bus.cmd_ready, 1);
        chk("ar_res_data", bus.res_data, 0);
        chk("ar_alu_in1", bus.alu_in1, 0);
        chk("ar_alu_opcode", bus.alu_opcode, 0);
        tick();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        drive(OP_SUB, 8'd10, 8'd3, 1'b0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("ar_sub_valid", bus.res_valid, 1);
        chk("ar_sub_data", bus.res_data, 16'h0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Command front-end and result back-end wrapped around the combinational 8-bit ALU (16-bit result, 4-bit opcode).
- Buffers operand/opcode commands in a small FIFO and registers them onto the ALU inputs.
- Captures the ALU result together with status flags, handshakes it to the consumer, and forwards the previous result as an operand for chained operations.
- ALU is instantiated by the parent; this block drives `alu_in1`/`alu_in2`/`alu_opcode` and samples `alu_result`.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- DW, 8, operand width
- OPW, 4, opcode width
- RW, 16, ALU result width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous pipeline/FIFO clear
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept
- cmd_opcode  input  OPW  ALU opcode
- cmd_in1  input  DW  operand 1
- cmd_in2  input  DW  operand 2
- cmd_chain  input  1  replace in1 with low byte of previous result
- alu_in1  output  DW  registered operand 1 to ALU
- alu_in2  output  DW  registered operand 2 to ALU
- alu_opcode  output  OPW  registered opcode to ALU
- alu_result  input  RW  combinational ALU result
- res_valid  output  1  result register full
- res_ready  input  1  consumer accepts
- res_data  output  RW  captured result
- res_opcode  output  OPW  opcode that produced res_data
- res_zero  output  1  res_data == 0
- res_ovf  output  1  res_data[RW-1:DW] != 0
- res_ill  output  1  opcode was 4'hF (illegal; ALU returns 0)
- fifo_count  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- **Reset** (rst=1, any time, asynchronous):
  - FIFO empty, fifo_count=0, cmd_ready=1.
  - S1 and S2 invalid; alu_in1/alu_in2/alu_opcode=0.
  - res_valid=0; res_data=0, res_opcode=0, all flags=0.
  - last_result=0.
  - In-flight commands are lost.
- **Push**:
  - Occurs when cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count < DEPTH); it ignores a same-cycle pop (no credit).
  - Entry stored = {chain, opcode, in1, in2}.
- **Stages**: FIFO -> S1 (operand register driving ALU) -> S2 (result register).
  - s2_load = s1_valid && (!res_valid || res_ready).
  - s1_load = fifo non-empty && (!s1_valid || s2_load) (pop).
  - No FIFO bypass: a command pushed at edge k is popped at edge k+1 at the earliest, and res_valid rises at edge k+2. Minimum latency is 2 cycles; throughput is 1 result/cycle.
- **S1 load**:
  - alu_in2 and alu_opcode take the head entry.
  - If chain=0: alu_in1 = head in1.
  - If chain=1 and s2_load at the same edge: alu_in1 = alu_result[DW-1:0] (forward from the op currently in S1).
  - If chain=1 otherwise: alu_in1 = last_result[DW-1:0].
- **S2 load**:
  - res_data = alu_result; res_opcode = alu_opcode.
  - res_zero, res_ovf, res_ill are computed from alu_result/alu_opcode.
  - last_result = alu_result.
- **Hold**:
  - While res_valid && !res_ready, S2 holds and S1 holds.
  - alu_* outputs stay stable, so the ALU output is stable.
- **res_valid**: drops after a handshake only if there is no s2_load at the same edge.
- **flush** (synchronous, priority over push/pop at the same edge):
  - FIFO empty, S1/S2 invalid, last_result=0.
  - res_data and flags are cleared to 0.
  - A cmd_valid at the flush edge is dropped.
- **Simultaneous push and pop** at the same edge: fifo_count is unchanged. Full with a pop means cmd_ready is still 0 that cycle.
- **Pointer wrap**: natural modulo DEPTH.
- **Chain as first command after reset/flush**: uses 0.

Decomposition:
- **Package alu_pkg**:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_SHL=3, OP_SHR=4, OP_PASS_A=5, OP_PASS_B=6, OP_AND=7, OP_OR=8, OP_NAND=9, OP_XOR=10, OP_XNOR=11, OP_EQ=12, OP_MAX=13, OP_MAX2=14, OP_ILL=15.
  - Widths DW/OPW/RW.
  - Command struct {chain, opcode, in1, in2}.
- **Sub-module alu_cmd_fifo**: synchronous FIFO with count, full/empty and flush. Pipeline, forwarding and flags stay in the top.

Test Plan:
- **Basic add**: reset, push ADD in1=200 in2=100, res_ready=1 -> res_valid 2 cycles after accept, res_data=0x012C, res_ovf=1, res_zero=0, res_ill=0.
- **Chained forwarding, back-to-back**: push MUL 3,5 then ADD chain=1 in2=1 on consecutive cycles -> results 15 (0x000F) then 16 (0x0010), no bubble.
- **Backpressure**: res_ready=0, offer 8 commands -> exactly 6 accepted (4 FIFO + S1 + S2), cmd_ready=0, fifo_count=4, res_data stable. Then res_ready=1 -> all 6 drain in order, one per cycle.
- **Zero/illegal flags**: push XOR 0x5A,0x5A -> res_data=0, res_zero=1. Push opcode 15 -> res_data=0, res_ill=1, res_zero=1.
- **Flush mid-stream**: 3 commands queued, flush for 1 cycle -> res_valid=0, fifo_count=0 next cycle. Then chain ADD in2=7 -> 7 (last_result cleared).
- **Async reset mid-operation**: assert rst between clock edges with a full pipeline -> outputs zero immediately, cmd_ready=1. After release, SUB 10,3 -> 0x0007.
